// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker: consumes the RX MAC stream and checks every frame
// against the TX generator's incrementing-byte pattern. It also checks the
// frame length, keep legality and the MAC error flag. Per-frame results,
// saturating good/bad counters and a sticky first-mismatch capture are kept.
module eth_rx_frame_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned HDR_BYTES  = 14,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1514,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_rx_clk,
  input  logic                  i_rx_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_terr,
  input  logic                  i_clear_stats,
  output logic                  o_frame_done,
  output logic                  o_frame_good,
  output logic [15:0]           o_frame_len,
  output logic [CNT_WIDTH-1:0]  o_good_cnt,
  output logic [CNT_WIDTH-1:0]  o_bad_cnt,
  output logic                  o_first_err_valid,
  output logic [CNT_WIDTH-1:0]  o_first_err_frame,
  output logic [15:0]           o_first_err_byte
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned POP_W = $clog2(CTRL_WIDTH + 1);

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_byte_idx;
  logic [LEN_W-1:0]     r_len;
  logic                 r_mis;
  logic                 r_keep_err;
  logic                 r_terr;
  logic [CNT_WIDTH-1:0] r_seq;
  logic                 r_done;
  logic                 r_good;
  logic [LEN_W-1:0]     r_frame_len;
  logic [CNT_WIDTH-1:0] r_good_cnt;
  logic [CNT_WIDTH-1:0] r_bad_cnt;
  logic                 r_fe_valid;
  logic [CNT_WIDTH-1:0] r_fe_frame;
  logic [LEN_W-1:0]     r_fe_byte;

  logic                 w_sof;
  logic [LEN_W-1:0]     w_base;
  logic [LEN_W-1:0]     w_len_prev;
  logic                 w_mis_prev;
  logic [POP_W-1:0]     w_pop;
  logic                 w_beat_mis;
  logic [LEN_W-1:0]     w_beat_mis_idx;
  logic [CTRL_WIDTH-1:0] w_keep_p1;
  logic                 w_keep_bad;
  logic [LEN_W:0]       w_len_sum;
  logic [LEN_W-1:0]     w_len_next;
  logic                 w_mis_next;
  logic                 w_keep_err_next;
  logic                 w_terr_next;
  logic                 w_frame_good;
  logic                 w_capture;
  logic [CNT_WIDTH-1:0] w_good_base;
  logic [CNT_WIDTH-1:0] w_bad_base;
  logic [CNT_WIDTH-1:0] w_good_inc;
  logic [CNT_WIDTH-1:0] w_bad_inc;

  // A beat seen in IDLE opens a new frame, so per-frame accumulators restart from zero
  always_comb begin
    w_sof      = (r_state == ST_IDLE);
    w_base     = w_sof ? '0 : r_byte_idx;
    w_len_prev = w_sof ? '0 : r_len;
    w_mis_prev = w_sof ? 1'b0 : r_mis;
  end

  // Lane popcount and pattern compare; lanes scanned high to low so the lowest mismatch wins
  always_comb begin
    w_pop          = '0;
    w_beat_mis     = 1'b0;
    w_beat_mis_idx = '0;
    for (int j = CTRL_WIDTH - 1; j >= 0; j--) begin
      if (s_axis_tkeep[j]) begin
        w_pop = w_pop + POP_W'(1);
        if (((w_base + LEN_W'(j)) >= LEN_W'(HDR_BYTES)) &&
            (s_axis_tdata[8*j +: 8] !=
             8'(r_seq[7:0] + 8'(w_base + LEN_W'(j)) - 8'(HDR_BYTES)))) begin
          w_beat_mis     = 1'b1;
          w_beat_mis_idx = w_base + LEN_W'(j);
        end
      end
    end
  end

  // Keep legality, saturating length and the frame verdict as of this beat
  always_comb begin
    w_keep_p1 = s_axis_tkeep + CTRL_WIDTH'(1);
    if (s_axis_tlast) begin
      w_keep_bad = (s_axis_tkeep == '0) || ((s_axis_tkeep & w_keep_p1) != '0);
    end else begin
      w_keep_bad = (s_axis_tkeep != '1);
    end
    w_len_sum       = {1'b0, w_len_prev} + (LEN_W + 1)'(w_pop);
    w_len_next      = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];
    w_mis_next      = w_mis_prev | w_beat_mis;
    w_keep_err_next = (w_sof ? 1'b0 : r_keep_err) | w_keep_bad;
    w_terr_next     = (w_sof ? 1'b0 : r_terr) | s_axis_terr;
    w_frame_good    = !w_mis_next && !w_keep_err_next && !w_terr_next &&
                      (w_len_next >= LEN_W'(MIN_LEN)) &&
                      (w_len_next <= LEN_W'(MAX_LEN));
    w_capture       = s_axis_tvalid && w_beat_mis && !w_mis_prev &&
                      (!r_fe_valid || i_clear_stats);
  end

  // A same-cycle clear is applied before the completing frame is counted
  always_comb begin
    w_good_base = i_clear_stats ? '0 : r_good_cnt;
    w_bad_base  = i_clear_stats ? '0 : r_bad_cnt;
    w_good_inc  = (&w_good_base) ? w_good_base : w_good_base + CNT_WIDTH'(1);
    w_bad_inc   = (&w_bad_base)  ? w_bad_base  : w_bad_base  + CNT_WIDTH'(1);
  end

  // Frame FSM, per-frame accumulators, completion outputs and statistics
  always_ff @(posedge i_rx_clk) begin
    if (i_rx_reset) begin
      r_state     <= ST_IDLE;
      r_byte_idx  <= '0;
      r_len       <= '0;
      r_mis       <= 1'b0;
      r_keep_err  <= 1'b0;
      r_terr      <= 1'b0;
      r_seq       <= '0;
      r_done      <= 1'b0;
      r_good      <= 1'b0;
      r_frame_len <= '0;
      r_good_cnt  <= '0;
      r_bad_cnt   <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_frame  <= '0;
      r_fe_byte   <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_clear_stats) begin
        r_good_cnt <= '0;
        r_bad_cnt  <= '0;
        r_fe_valid <= 1'b0;
        r_fe_frame <= '0;
        r_fe_byte  <= '0;
      end
      if (w_capture) begin
        r_fe_valid <= 1'b1;
        r_fe_frame <= r_seq;
        r_fe_byte  <= w_beat_mis_idx;
      end
      if (s_axis_tvalid) begin
        r_byte_idx <= w_base + LEN_W'(CTRL_WIDTH);
        r_len      <= w_len_next;
        r_mis      <= w_mis_next;
        r_keep_err <= w_keep_err_next;
        r_terr     <= w_terr_next;
        if (s_axis_tlast) begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b1;
          r_good      <= w_frame_good;
          r_frame_len <= w_len_next;
          r_seq       <= r_seq + CNT_WIDTH'(1);
          if (w_frame_good) begin
            r_good_cnt <= w_good_inc;
          end else begin
            r_bad_cnt <= w_bad_inc;
          end
        end else begin
          r_state <= ST_FRAME;
        end
      end
    end
  end

  assign o_frame_done      = r_done;
  assign o_frame_good      = r_good;
  assign o_frame_len       = r_frame_len;
  assign o_good_cnt        = r_good_cnt;
  assign o_bad_cnt         = r_bad_cnt;
  assign o_first_err_valid = r_fe_valid;
  assign o_first_err_frame = r_fe_frame;
  assign o_first_err_byte  = r_fe_byte;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Bench for eth_rx_frame_checker: frames are built as byte-level beat lists,
// and a frame-level reference model plus scoreboard predicts each result.
module tb_eth_rx_frame_checker;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;
  localparam int unsigned HDR  = 14;
  localparam int unsigned MINL = 60;
  localparam int unsigned MAXL = 1514;
  localparam int unsigned CNTW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   tdata;
  logic [CW-1:0]   tkeep;
  logic            tvalid, tlast, terr, clr;
  logic            done, fgood, fev;
  logic [15:0]     flen, feb;
  logic [CNTW-1:0] gcnt, bcnt, fef;

  always #5 clk = ~clk;

  eth_rx_frame_checker #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .HDR_BYTES(HDR),
    .MIN_LEN(MINL), .MAX_LEN(MAXL), .CNT_WIDTH(CNTW)
  ) dut (
    .i_rx_clk(clk), .i_rx_reset(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_terr(terr), .i_clear_stats(clr),
    .o_frame_done(done), .o_frame_good(fgood), .o_frame_len(flen),
    .o_good_cnt(gcnt), .o_bad_cnt(bcnt), .o_first_err_valid(fev),
    .o_first_err_frame(fef), .o_first_err_byte(feb)
  );

  int total = 0;
  int bad   = 0;

  // frame under test, one entry per beat
  logic [DW-1:0] bd[$];
  logic [CW-1:0] bk[$];
  logic          be[$];

  // scoreboard state and prediction for the last modelled frame
  int unsigned m_seq, m_good, m_bad, m_fe_frame, m_fe_byte;
  bit          m_fe_v;
  bit          x_good;
  int unsigned x_len;
  logic        obs_pre_done;

  task automatic model_reset();
    m_seq = 0; m_good = 0; m_bad = 0; m_fe_v = 0; m_fe_frame = 0; m_fe_byte = 0;
  endtask

  task automatic model_clear();
    m_good = 0; m_bad = 0; m_fe_v = 0; m_fe_frame = 0; m_fe_byte = 0;
  endtask

  // byte-level reference: positional byte index = beat*CW + lane
  task automatic model_frame();
    int unsigned len, idx, mis_idx;
    bit mis, kerr, terr_seen, gap;
    logic [DW-1:0] d;
    logic [CW-1:0] k;
    logic [7:0] want;
    len = 0; mis = 0; mis_idx = 0; kerr = 0; terr_seen = 0;
    for (int i = 0; i < bd.size(); i++) begin
      d = bd[i]; k = bk[i];
      if (be[i]) terr_seen = 1;
      if (i < bd.size() - 1) begin
        if (k != {CW{1'b1}}) kerr = 1;
      end else begin
        if (k == '0) kerr = 1;
        gap = 0;
        for (int j = 0; j < CW; j++) begin
          if (!k[j]) gap = 1;
          else if (gap) kerr = 1;
        end
      end
      for (int j = 0; j < CW; j++) begin
        if (k[j]) begin
          idx  = i * CW + j;
          want = 8'(m_seq + idx - HDR);
          len++;
          if (idx >= HDR && d[8*j +: 8] != want && !mis) begin
            mis = 1; mis_idx = idx;
          end
        end
      end
    end
    x_len  = len;
    x_good = !mis && !kerr && !terr_seen && len >= MINL && len <= MAXL;
    if (mis && !m_fe_v) begin
      m_fe_v = 1; m_fe_frame = m_seq; m_fe_byte = mis_idx;
    end
    if (x_good) m_good++; else m_bad++;
    m_seq++;
  endtask

  task automatic build_clean(input int unsigned len);
    logic [DW-1:0] d;
    logic [CW-1:0] k;
    int unsigned idx;
    bd.delete(); bk.delete(); be.delete();
    for (int unsigned b = 0; b * CW < len; b++) begin
      d = '0; k = '0;
      for (int j = 0; j < CW; j++) begin
        idx = b * CW + j;
        if (idx < len) begin
          k[j] = 1'b1;
          d[8*j +: 8] = (idx < HDR) ? 8'($urandom) : 8'(m_seq + idx - HDR);
        end
      end
      bd.push_back(d); bk.push_back(k); be.push_back(1'b0);
    end
  endtask

  task automatic corrupt(input int unsigned idx);
    logic [DW-1:0] d;
    d = bd[idx / CW];
    d[8*(idx % CW) +: 8] = d[8*(idx % CW) +: 8] ^ 8'($urandom_range(1, 255));
    bd[idx / CW] = d;
  endtask

  task automatic do_reset();
    tvalid = 0; tlast = 0; terr = 0; clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic idle(input int n);
    tvalid = 0; tlast = 0; terr = 0; clr = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // drives the queued beats; returns #1 after the last beat's edge so the done cycle is visible
  task automatic send_frame(input bit clear_on_last);
    for (int i = 0; i < bd.size(); i++) begin
      tdata = bd[i]; tkeep = bk[i]; terr = be[i]; tvalid = 1;
      tlast = (i == bd.size() - 1);
      clr   = clear_on_last && tlast;
      if (tlast) obs_pre_done = done;
      @(posedge clk); #1;
    end
    tvalid = 0; tlast = 0; terr = 0; clr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (fgood !== 1'b0) begin bad++; $display("FAIL reset_good: got %0b want 0", fgood); end
    total++; if (flen !== 16'd0) begin bad++; $display("FAIL reset_len: got %0d want 0", flen); end
    total++; if (gcnt !== '0 || bcnt !== '0) begin bad++; $display("FAIL reset_cnts: got %0d/%0d want 0/0", gcnt, bcnt); end
    total++; if (fev !== 1'b0 || fef !== '0 || feb !== 16'd0) begin bad++; $display("FAIL reset_capture: got %0b/%0d/%0d want 0/0/0", fev, fef, feb); end
  endtask

  task automatic test_good_frames();
    build_clean(64); model_frame(); send_frame(0);
    total++; if (obs_pre_done !== 1'b0) begin bad++; $display("FAIL good64_early_done: got %0b want 0", obs_pre_done); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL good64_done: got %0b want 1", done); end
    total++; if (fgood !== x_good) begin bad++; $display("FAIL good64_good: got %0b want %0b", fgood, x_good); end
    total++; if (flen !== 16'(x_len)) begin bad++; $display("FAIL good64_len: got %0d want %0d", flen, x_len); end
    total++; if (gcnt !== m_good) begin bad++; $display("FAIL good64_cnt: got %0d want %0d", gcnt, m_good); end
    // second frame starts on the very next cycle
    build_clean(61); model_frame(); send_frame(0);
    total++; if (done !== 1'b1 || fgood !== x_good) begin bad++; $display("FAIL good61_result: got %0b/%0b want 1/%0b", done, fgood, x_good); end
    total++; if (flen !== 16'(x_len)) begin bad++; $display("FAIL good61_len: got %0d want %0d", flen, x_len); end
    total++; if (gcnt !== m_good) begin bad++; $display("FAIL good61_cnt: got %0d want %0d", gcnt, m_good); end
    idle(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %0b want 0", done); end
    total++; if (flen !== 16'(x_len)) begin bad++; $display("FAIL len_hold: got %0d want %0d", flen, x_len); end
  endtask

  task automatic test_mismatch();
    build_clean(64); corrupt(20); model_frame(); send_frame(0);
    total++; if (fgood !== x_good) begin bad++; $display("FAIL mis_good: got %0b want %0b", fgood, x_good); end
    total++; if (bcnt !== m_bad) begin bad++; $display("FAIL mis_bad_cnt: got %0d want %0d", bcnt, m_bad); end
    total++; if (fev !== m_fe_v) begin bad++; $display("FAIL mis_fe_valid: got %0b want %0b", fev, m_fe_v); end
    total++; if (fef !== m_fe_frame) begin bad++; $display("FAIL mis_fe_frame: got %0d want %0d", fef, m_fe_frame); end
    total++; if (feb !== 16'(m_fe_byte)) begin bad++; $display("FAIL mis_fe_byte: got %0d want %0d", feb, m_fe_byte); end
    idle(2);
    build_clean(64); model_frame(); send_frame(0);
    total++; if (fgood !== x_good) begin bad++; $display("FAIL after_mis_good: got %0b want %0b", fgood, x_good); end
    total++; if (fef !== m_fe_frame || feb !== 16'(m_fe_byte)) begin bad++; $display("FAIL capture_sticky: got %0d/%0d want %0d/%0d", fef, feb, m_fe_frame, m_fe_byte); end
  endtask

  task automatic test_keep_and_errors();
    build_clean(64); bk[3] = 4'h3; model_frame(); send_frame(0);
    total++; if (fgood !== x_good || flen !== 16'(x_len)) begin bad++; $display("FAIL keep_mid: got %0b/%0d want %0b/%0d", fgood, flen, x_good, x_len); end
    build_clean(63); bk[15] = 4'h5; model_frame(); send_frame(0);
    total++; if (fgood !== x_good || flen !== 16'(x_len)) begin bad++; $display("FAIL keep_last_gap: got %0b/%0d want %0b/%0d", fgood, flen, x_good, x_len); end
    idle(1);
    build_clean(4); model_frame(); send_frame(0);
    total++; if (done !== 1'b1 || fgood !== x_good || flen !== 16'(x_len)) begin bad++; $display("FAIL runt_single: got %0b/%0b/%0d want 1/%0b/%0d", done, fgood, flen, x_good, x_len); end
    build_clean(64); be[15] = 1'b1; model_frame(); send_frame(0);
    total++; if (fgood !== x_good) begin bad++; $display("FAIL terr_last: got %0b want %0b", fgood, x_good); end
    total++; if (gcnt !== m_good || bcnt !== m_bad) begin bad++; $display("FAIL err_cnts: got %0d/%0d want %0d/%0d", gcnt, bcnt, m_good, m_bad); end
  endtask

  task automatic test_len_bounds();
    int unsigned lens[4] = '{60, 59, 1514, 1515};
    for (int i = 0; i < 4; i++) begin
      build_clean(lens[i]); model_frame(); send_frame(0);
      total++; if (fgood !== x_good || flen !== 16'(x_len)) begin bad++; $display("FAIL len_bound_%0d: got %0b/%0d want %0b/%0d", lens[i], fgood, flen, x_good, x_len); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    build_clean(64);
    for (int i = 0; i < 5; i++) begin
      tdata = bd[i]; tkeep = bk[i]; terr = 0; tlast = 0; tvalid = 1;
      @(posedge clk); #1;
    end
    do_reset();
    repeat (5) begin void'(bd.pop_front()); void'(bk.pop_front()); void'(be.pop_front()); end
    model_frame(); send_frame(0);
    total++; if (flen !== 16'(x_len) || fgood !== x_good) begin bad++; $display("FAIL midreset_frame: got %0d/%0b want %0d/%0b", flen, fgood, x_len, x_good); end
    total++; if (bcnt !== m_bad || feb !== 16'(m_fe_byte) || fef !== m_fe_frame) begin bad++; $display("FAIL midreset_stats: got %0d/%0d/%0d want %0d/%0d/%0d", bcnt, feb, fef, m_bad, m_fe_byte, m_fe_frame); end
    idle(1);
    build_clean(64); model_frame(); send_frame(0);
    total++; if (fgood !== x_good) begin bad++; $display("FAIL midreset_next: got %0b want %0b", fgood, x_good); end
  endtask

  task automatic test_clear_stats();
    // clear is sampled on the same edge that completes the frame
    build_clean(64); model_clear(); model_frame(); send_frame(1);
    total++; if (gcnt !== m_good || bcnt !== m_bad) begin bad++; $display("FAIL clear_cnts: got %0d/%0d want %0d/%0d", gcnt, bcnt, m_good, m_bad); end
    total++; if (fev !== m_fe_v || fef !== m_fe_frame || feb !== 16'(m_fe_byte)) begin bad++; $display("FAIL clear_capture: got %0b/%0d/%0d want %0b/%0d/%0d", fev, fef, feb, m_fe_v, m_fe_frame, m_fe_byte); end
    build_clean(64); model_frame(); send_frame(0);
    total++; if (fgood !== x_good || gcnt !== m_good) begin bad++; $display("FAIL clear_next: got %0b/%0d want %0b/%0d", fgood, gcnt, x_good, m_good); end
  endtask

  task automatic test_back_to_back();
    int unsigned len, sel, bi;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(40, 160);
      build_clean(len);
      sel = $urandom_range(0, 9);
      if (sel <= 1) corrupt($urandom_range(HDR, len - 1));
      else if (sel == 2) corrupt($urandom_range(0, HDR - 1));
      else if (sel == 3) begin bi = $urandom_range(0, bd.size() - 2); bk[bi] = 4'($urandom_range(0, 14)); end
      else if (sel == 4) be[$urandom_range(0, be.size() - 1)] = 1'b1;
      model_frame(); send_frame(0);
      total++; if (done !== 1'b1 || fgood !== x_good || flen !== 16'(x_len)) begin bad++; $display("FAIL rand_frame_%0d: got %0b/%0b/%0d want 1/%0b/%0d", f, done, fgood, flen, x_good, x_len); end
      total++; if (gcnt !== m_good || bcnt !== m_bad) begin bad++; $display("FAIL rand_cnts_%0d: got %0d/%0d want %0d/%0d", f, gcnt, bcnt, m_good, m_bad); end
      total++; if (fev !== m_fe_v || fef !== m_fe_frame || feb !== 16'(m_fe_byte)) begin bad++; $display("FAIL rand_capture_%0d: got %0b/%0d/%0d want %0b/%0d/%0d", f, fev, fef, feb, m_fe_v, m_fe_frame, m_fe_byte); end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1; tdata = '0; tkeep = '0; tvalid = 0; tlast = 0; terr = 0; clr = 0;
    test_reset();
    test_good_frames();
    test_mismatch();
    test_keep_and_errors();
    test_len_bounds();
    test_reset_midframe();
    test_clear_stats();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
